// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised general-purpose register file for the CPU datapath.
// Two registered read ports, one write port with full/half-word modes, a 2-bit
// {overflow, carry} flag register, optional write-to-read bypass, optional
// hardwired zero register and a write-lock used while the core is halted.
module reg_file_2r1w #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [1:0]        wr_mode,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              flag_we,
    input  logic [1:0]        flag_in,
    output logic [1:0]        flags,
    input  logic              lock,
    input  logic              unlock,
    output logic              locked,
    output logic              wr_err
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned HALF_W = DATA_W / 2;

    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_LOW  = 2'b01;
    localparam logic [1:0] MODE_HIGH = 2'b10;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t       state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic [1:0]        flags_q, flags_d;
    logic              wr_err_q, wr_err_d;

    logic              mode_ok;
    logic              wr_accept;
    logic              wr_hit;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_new;

    // Lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock next-state: lock wins over unlock
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNLOCKED: if (lock) state_d = ST_LOCKED;
            ST_LOCKED:   if (unlock && !lock) state_d = ST_UNLOCKED;
            default:     state_d = ST_UNLOCKED;
        endcase
    end

    // Lock output decode
    always_comb begin
        locked = 1'b0;
        if (state_q == ST_LOCKED) locked = 1'b1;
    end

    // Write qualification and half-word merge
    always_comb begin
        mode_ok   = (wr_mode != 2'b11);
        wr_accept = wr_en && !locked && mode_ok;
        wr_hit    = wr_accept && !(ZERO_REG && (wr_addr == '0));
        wr_old    = mem_q[wr_addr];
        wr_new    = wr_data;
        case (wr_mode)
            MODE_FULL: wr_new = wr_data;
            MODE_LOW:  wr_new = {wr_old[DATA_W-1:HALF_W], wr_data[HALF_W-1:0]};
            MODE_HIGH: wr_new = {wr_data[HALF_W-1:0], wr_old[HALF_W-1:0]};
            default:   wr_new = wr_old;
        endcase
    end

    // Next register contents, flags and error pulse
    always_comb begin
        mem_d = mem_q;
        if (wr_hit) mem_d[wr_addr] = wr_new;
        flags_d = flags_q;
        if (flag_we && !locked) flags_d = flag_in;
        wr_err_d = wr_en && (locked || !mode_ok);
    end

    // Read port selection with optional same-cycle bypass
    always_comb begin
        rd_a_d = mem_q[rd_a_addr];
        rd_b_d = mem_q[rd_b_addr];
        if (BYPASS && wr_hit && (wr_addr == rd_a_addr)) rd_a_d = wr_new;
        if (BYPASS && wr_hit && (wr_addr == rd_b_addr)) rd_b_d = wr_new;
        if (ZERO_REG && (rd_a_addr == '0)) rd_a_d = '0;
        if (ZERO_REG && (rd_b_addr == '0)) rd_b_d = '0;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            flags_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
            flags_q  <= flags_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_q;
    assign flags     = flags_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: two instances share stimulus, one with default
// parameters (bypass on, no zero register) and one with bypass off and a
// hardwired zero register.
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_mode;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_a_addr;
    logic [2:0]  rd_b_addr;
    logic        flag_we;
    logic [1:0]  flag_in;
    logic        lock;
    logic        unlock;

    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  fl0, fl1;
    logic        lk0, lk1, er0, er1;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m0 [8];
    logic [15:0] m1 [8];
    logic        m_locked;
    logic [15:0] e_a0, e_b0, e_a1, e_b1;
    logic [1:0]  e_flags;
    logic        e_locked, e_err;

    reg_file_2r1w u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_mode(wr_mode),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_a_addr(rd_a_addr),
        .rd_b_addr(rd_b_addr), .rd_a_data(a0), .rd_b_data(b0),
        .flag_we(flag_we), .flag_in(flag_in), .flags(fl0),
        .lock(lock), .unlock(unlock), .locked(lk0), .wr_err(er0)
    );

    reg_file_2r1w #(.BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_mode(wr_mode),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_a_addr(rd_a_addr),
        .rd_b_addr(rd_b_addr), .rd_a_data(a1), .rd_b_data(b1),
        .flag_we(flag_we), .flag_in(flag_in), .flags(fl1),
        .lock(lock), .unlock(unlock), .locked(lk1), .wr_err(er1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] mode);
        int unsigned o, v;
        o = int'(old);
        v = int'(d);
        case (mode)
            2'd1:    return 16'((o / 256) * 256 + (v % 256));
            2'd2:    return 16'((v % 256) * 256 + (o % 256));
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m0[i] = 16'h0;
            m1[i] = 16'h0;
        end
        m_locked = 1'b0;
        e_flags  = 2'b00;
    endtask

    // Advance the reference model by one clock edge using the current inputs
    task automatic model_step();
        logic [15:0] n0 [8];
        logic [15:0] n1 [8];
        bit acc;
        n0 = m0;
        n1 = m1;
        acc = wr_en && !m_locked && (wr_mode != 2'd3);
        if (acc) begin
            n0[wr_addr] = merge(m0[wr_addr], wr_data, wr_mode);
            if (wr_addr != 3'd0) n1[wr_addr] = merge(m1[wr_addr], wr_data, wr_mode);
        end
        e_a0 = n0[rd_a_addr];
        e_b0 = n0[rd_b_addr];
        e_a1 = (rd_a_addr == 3'd0) ? 16'h0 : m1[rd_a_addr];
        e_b1 = (rd_b_addr == 3'd0) ? 16'h0 : m1[rd_b_addr];
        e_err = wr_en && (m_locked || (wr_mode == 2'd3));
        if (flag_we && !m_locked) e_flags = flag_in;
        e_locked = lock ? 1'b1 : (unlock ? 1'b0 : m_locked);
        m0 = n0;
        m1 = n1;
        m_locked = e_locked;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_mode = 0; wr_addr = 0; wr_data = 0;
        rd_a_addr = 0; rd_b_addr = 0;
        flag_we = 0; flag_in = 0; lock = 0; unlock = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (fl0 !== 2'b00 || lk0 !== 1'b0 || er0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: flags=%b locked=%b wr_err=%b expected 00 0 0", fl0, lk0, er0);
        end
        for (int i = 0; i < 8; i++) begin
            rd_a_addr = 3'(i);
            rd_b_addr = 3'(7 - i);
            tick();
            checks++;
            if (a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 16'h0 || b1 !== 16'h0) begin
                errors++;
                $display("FAIL reset_read[%0d]: a0=%h b0=%h a1=%h b1=%h expected 0000", i, a0, b0, a1, b1);
            end
        end
    endtask

    task automatic test_half_write();
        logic [15:0] exp_v [3];
        logic [15:0] dat [3];
        logic [1:0]  mode [3];
        exp_v = '{16'hA5C3, 16'h7EC3, 16'h7E11};
        dat   = '{16'hA5C3, 16'h007E, 16'h0011};
        mode  = '{2'd0, 2'd2, 2'd1};
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_addr = 3'd3; wr_data = dat[i]; wr_mode = mode[i];
            rd_a_addr = 3'd0; rd_b_addr = 3'd0;
            tick();
            wr_en = 0; rd_a_addr = 3'd3; rd_b_addr = 3'd3;
            tick();
            checks++;
            if (a0 !== exp_v[i] || b0 !== exp_v[i] || a1 !== exp_v[i]) begin
                errors++;
                $display("FAIL half_write[%0d]: a0=%h b0=%h a1=%h expected %h", i, a0, b0, a1, exp_v[i]);
            end
        end
    endtask

    task automatic test_bypass();
        reset_dut();
        wr_en = 1; wr_mode = 0; wr_addr = 3'd5; wr_data = 16'h1234;
        rd_a_addr = 3'd5; rd_b_addr = 3'd5;
        tick();
        wr_en = 0;
        checks++;
        if (a0 !== 16'h1234 || b0 !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_on: a0=%h b0=%h expected 1234", a0, b0);
        end
        checks++;
        if (a1 !== 16'h0000 || b1 !== 16'h0000) begin
            errors++;
            $display("FAIL bypass_off_old: a1=%h b1=%h expected 0000", a1, b1);
        end
        tick();
        checks++;
        if (a1 !== 16'h1234 || b1 !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_off_new: a1=%h b1=%h expected 1234", a1, b1);
        end
    endtask

    task automatic test_lock();
        reset_dut();
        wr_en = 1; wr_mode = 0; wr_addr = 3'd1; wr_data = 16'hBEEF; lock = 1;
        rd_a_addr = 3'd1;
        tick();
        wr_en = 0; lock = 0;
        tick();
        checks++;
        if (a0 !== 16'hBEEF || a1 !== 16'hBEEF || lk0 !== 1'b1 || lk1 !== 1'b1) begin
            errors++;
            $display("FAIL lock_entry: a0=%h a1=%h locked=%b expected BEEF 1", a0, a1, lk0);
        end
        wr_en = 1; wr_data = 16'h0001;
        tick();
        wr_en = 0;
        checks++;
        if (er0 !== 1'b1 || er1 !== 1'b1) begin
            errors++;
            $display("FAIL lock_err: wr_err=%b/%b expected 1", er0, er1);
        end
        flag_we = 1; flag_in = 2'b11;
        tick();
        flag_we = 0;
        checks++;
        if (a0 !== 16'hBEEF || er0 !== 1'b0 || fl0 !== 2'b00 || fl1 !== 2'b00) begin
            errors++;
            $display("FAIL lock_hold: a0=%h wr_err=%b flags=%b expected BEEF 0 00", a0, er0, fl0);
        end
        lock = 1; unlock = 1;
        tick();
        checks++;
        if (lk0 !== 1'b1) begin
            errors++;
            $display("FAIL lock_priority: locked=%b expected 1", lk0);
        end
        lock = 0;
        tick();
        unlock = 0;
        checks++;
        if (lk0 !== 1'b0 || lk1 !== 1'b0) begin
            errors++;
            $display("FAIL unlock: locked=%b expected 0", lk0);
        end
        wr_en = 1; wr_data = 16'h0001;
        tick();
        wr_en = 0;
        tick();
        checks++;
        if (a0 !== 16'h0001 || a1 !== 16'h0001 || er0 !== 1'b0) begin
            errors++;
            $display("FAIL unlock_write: a0=%h a1=%h wr_err=%b expected 0001 0", a0, a1, er0);
        end
    endtask

    task automatic test_reserved_zero();
        reset_dut();
        wr_en = 1; wr_mode = 2'd3; wr_addr = 3'd2; wr_data = 16'h5555;
        rd_a_addr = 3'd2;
        tick();
        wr_en = 0; wr_mode = 0;
        checks++;
        if (er0 !== 1'b1 || a0 !== 16'h0000) begin
            errors++;
            $display("FAIL reserved_mode: wr_err=%b a0=%h expected 1 0000", er0, a0);
        end
        tick();
        checks++;
        if (er0 !== 1'b0 || a0 !== 16'h0000) begin
            errors++;
            $display("FAIL reserved_pulse: wr_err=%b a0=%h expected 0 0000", er0, a0);
        end
        wr_en = 1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_a_addr = 3'd0; rd_b_addr = 3'd0;
        tick();
        wr_en = 0;
        checks++;
        if (er1 !== 1'b0 || a1 !== 16'h0000 || a0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL zero_reg_write: wr_err=%b a1=%h a0=%h expected 0 0000 FFFF", er1, a1, a0);
        end
        tick();
        checks++;
        if (a1 !== 16'h0000 || b1 !== 16'h0000 || er1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_read: a1=%h b1=%h wr_err=%b expected 0000 0000 0", a1, b1, er1);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        wr_en = 1; wr_mode = 0; wr_addr = 3'd7; wr_data = 16'hFFFF;
        flag_we = 1; flag_in = 2'b10;
        tick();
        wr_en = 0; flag_we = 0; rd_a_addr = 3'd7; rd_b_addr = 3'd7;
        tick();
        checks++;
        if (a0 !== 16'hFFFF || b1 !== 16'hFFFF || fl0 !== 2'b10) begin
            errors++;
            $display("FAIL async_preload: a0=%h b1=%h flags=%b expected FFFF FFFF 10", a0, b1, fl0);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 16'h0 || b1 !== 16'h0 ||
            fl0 !== 2'b00 || fl1 !== 2'b00 || lk0 !== 1'b0 || er0 !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: a0=%h b0=%h a1=%h b1=%h flags=%b expected all 0",
                     a0, b0, a1, b1, fl0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (a0 !== 16'h0 || a1 !== 16'h0) begin
            errors++;
            $display("FAIL async_r7: a0=%h a1=%h expected 0000", a0, a1);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            wr_en     = 1'($urandom_range(0, 3) != 0);
            wr_mode   = 2'($urandom_range(0, 3));
            wr_addr   = 3'($urandom);
            wr_data   = 16'($urandom);
            rd_a_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            rd_b_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            flag_we   = 1'($urandom);
            flag_in   = 2'($urandom);
            lock      = 1'($urandom_range(0, 9) == 0);
            unlock    = 1'($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if (a0 !== e_a0 || b0 !== e_b0 || a1 !== e_a1 || b1 !== e_b1) begin
                errors++;
                $display("FAIL rand_read[%0d]: a0=%h b0=%h a1=%h b1=%h expected %h %h %h %h",
                         n, a0, b0, a1, b1, e_a0, e_b0, e_a1, e_b1);
            end
            checks++;
            if (fl0 !== e_flags || fl1 !== e_flags || lk0 !== e_locked || lk1 !== e_locked ||
                er0 !== e_err || er1 !== e_err) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: flags=%b locked=%b wr_err=%b expected %b %b %b",
                         n, fl0, lk0, er0, e_flags, e_locked, e_err);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_half_write();
        test_bypass();
        test_lock();
        test_reserved_zero();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
